// File: rtl/slink_arb_pkg.sv
// Shared definitions for the SLINK transmit arbiter.
//   SLINK_DW  : width of one SLINK word (SOP, EOP, 16-bit payload)
//   SOP_BIT   : start-of-packet flag position
//   EOP_BIT   : end-of-packet flag position
//   TERM_WORD : word sent in place of the rest of an aborted packet
//   arb_state_e : arbiter FSM states
package slink_arb_pkg;

    localparam int SLINK_DW = 18;
    localparam int SOP_BIT  = 17;
    localparam int EOP_BIT  = 16;

    // EOP only, empty payload: closes an aborted packet at the receiver
    localparam logic [SLINK_DW-1:0] TERM_WORD = 18'h1_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req       : request vector, one bit per requester
//   ptr       : last served requester; the search starts at ptr+1 and wraps
//   gnt_valid : at least one request is set
//   gnt_idx   : index of the chosen requester (0 when gnt_valid is low)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic [IW-1:0] idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        // Walk N positions starting just after the last winner; first hit wins
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/slink_tx_arb.sv
// Round-robin packet arbiter sharing one SLINK TX channel between N_SRC
// source FIFOs. A source is granted for a whole packet; SLINK word pulls
// are forwarded to the granted FIFO one at a time, and each returned word
// is registered onto slink_data. A fixed idle gap follows every packet, and
// a read whose data never returns is closed with a terminator word.
//   clk_125m, rst_125m_n : clock, asynchronous active-low reset
//   src_en / src_empty   : per-source enable and FIFO empty flags
//   src_rdreq            : FIFO read strobe to the granted source only
//   src_data / src_dval  : packed FIFO read data (18 bits per source), valid
//   slink_rdreq          : word pull from SLINK TX
//   slink_data/_dval     : word and valid towards SLINK TX
//   grant_id             : current or most recent granted source
//   busy                 : arbiter is not idle
//   arb_err / sop_err    : one-cycle pulses on timeout abort / missing SOP
module slink_tx_arb
    import slink_arb_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int GAP_CYC = 8,
    parameter int TIMEOUT = 2048,
    parameter int IDW     = 2
) (
    input  logic                      clk_125m,
    input  logic                      rst_125m_n,
    input  logic [N_SRC-1:0]          src_en,
    input  logic [N_SRC-1:0]          src_empty,
    output logic [N_SRC-1:0]          src_rdreq,
    input  logic [N_SRC*SLINK_DW-1:0] src_data,
    input  logic [N_SRC-1:0]          src_dval,
    input  logic                      slink_rdreq,
    output logic [SLINK_DW-1:0]       slink_data,
    output logic                      slink_dval,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy,
    output logic                      arb_err,
    output logic                      sop_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    arb_state_e          state, state_nxt;
    logic [IDW-1:0]      ptr;
    logic                pend;
    logic                first_wd;
    logic [TW-1:0]       tcnt;
    logic [GW-1:0]       gcnt;
    logic [SLINK_DW-1:0] data_p1;
    logic                vld_p1;

    logic [N_SRC-1:0]    req;
    logic                pick_vld;
    logic [IDW-1:0]      pick_idx;
    logic [SLINK_DW-1:0] src_word [N_SRC];
    logic [SLINK_DW-1:0] gnt_word;
    logic                rd_g;
    logic                take;
    logic                eop_hit;
    logic                tmo_hit;

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign src_word[i] = src_data[i*SLINK_DW +: SLINK_DW];
    end

    assign req      = src_en & ~src_empty;
    assign gnt_word = src_word[grant_id];

    rr_pick #(
        .N  (N_SRC),
        .IW (IDW)
    ) u_pick (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (pick_vld),
        .gnt_idx   (pick_idx)
    );

    always_ff @(posedge clk_125m or negedge rst_125m_n) begin
        if (!rst_125m_n) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_g      = 1'b0;
        take      = 1'b0;
        eop_hit   = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) state_nxt = XFER;
            end
            XFER: begin
                // Only one read in flight; the next pull waits for its data
                rd_g    = slink_rdreq & ~src_empty[grant_id] & ~pend;
                take    = pend & src_dval[grant_id];
                eop_hit = take & gnt_word[EOP_BIT];
                // A dval arriving on the last count still wins over the abort
                tmo_hit = pend & ~src_dval[grant_id] & (tcnt == TMO_LAST);
                if (eop_hit || tmo_hit) state_nxt = GAP;
            end
            GAP: begin
                if (gcnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        src_rdreq           = '0;
        src_rdreq[grant_id] = rd_g;
    end

    assign busy = (state != IDLE);

    // p0 -> p1: FIFO word (or terminator) registered onto the SLINK side
    always_ff @(posedge clk_125m or negedge rst_125m_n) begin
        if (!rst_125m_n) begin
            ptr      <= IDW'(N_SRC - 1);
            grant_id <= IDW'(N_SRC - 1);
            pend     <= 1'b0;
            first_wd <= 1'b0;
            tcnt     <= '0;
            gcnt     <= '0;
            data_p1  <= '0;
            vld_p1   <= 1'b0;
            arb_err  <= 1'b0;
            sop_err  <= 1'b0;
        end else begin
            vld_p1  <= 1'b0;
            arb_err <= 1'b0;
            sop_err <= 1'b0;

            if (state == IDLE && pick_vld) begin
                grant_id <= pick_idx;
                first_wd <= 1'b1;
                pend     <= 1'b0;
                tcnt     <= '0;
            end

            if (rd_g) begin
                pend <= 1'b1;
                tcnt <= '0;
            end

            if (take) begin
                pend     <= 1'b0;
                tcnt     <= '0;
                data_p1  <= gnt_word;
                vld_p1   <= 1'b1;
                first_wd <= 1'b0;
                sop_err  <= first_wd & ~gnt_word[SOP_BIT];
            end else if (pend) begin
                tcnt <= tcnt + 1'b1;
            end

            if (tmo_hit) begin
                pend    <= 1'b0;
                tcnt    <= '0;
                data_p1 <= TERM_WORD;
                vld_p1  <= 1'b1;
                arb_err <= 1'b1;
            end

            if (eop_hit || tmo_hit) ptr <= grant_id;

            if (state == GAP) gcnt <= gcnt + 1'b1;
            else              gcnt <= '0;
        end
    end

    assign slink_data = data_p1;
    assign slink_dval = vld_p1;

endmodule
